// File: rtl/normalizer_32_pkg.sv
// Shared types and constants for the iterative 32-bit normalizer.
package normalizer_32_pkg;

  localparam int NORM_W  = 32;
  localparam int NORM_SW = 5;
  localparam int NORM_STAGES = 5;

  typedef enum logic [1:0] {
    NORM_IDLE = 2'd0,
    NORM_RUN  = 2'd1,
    NORM_DONE = 2'd2
  } norm_state_t;

  // Binary-search step size for a given stage: 16, 8, 4, 2, 1.
  function automatic logic [NORM_SW-1:0] stage_amt(input logic [2:0] stage);
    logic [NORM_SW-1:0] amt;
    case (stage)
      3'd0:    amt = 5'd16;
      3'd1:    amt = 5'd8;
      3'd2:    amt = 5'd4;
      3'd3:    amt = 5'd2;
      default: amt = 5'd1;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/normalizer_32_stage.sv
// One binary-search step: decides whether the top bits of the word are
// redundant for this step size and offers the word shifted by that amount.
module norm_stage
  import normalizer_32_pkg::*;
(
  input  logic [NORM_W-1:0]  work,
  input  logic [NORM_SW-1:0] amt,
  input  logic               signed_mode,
  output logic [NORM_W-1:0]  shifted,
  output logic               take
);

  logic [NORM_W-1:0] umask, smask, ubits, sbits;

  // Unsigned looks at the top amt bits; signed at the top amt+1 bits, which
  // must all match so the sign survives the shift.
  always_comb begin
    umask   = ~({NORM_W{1'b1}} >> amt);
    smask   = ~({NORM_W{1'b1}} >> ({1'b0, amt} + 6'd1));
    ubits   = work & umask;
    sbits   = work & smask;
    take    = signed_mode ? ((sbits == '0) || (sbits == smask)) : (ubits == '0);
    shifted = work << amt;
  end

endmodule

// File: rtl/normalizer_32.sv
// Iterative normalizer: leading-zero (unsigned) or redundant-sign-bit (signed)
// count found by a 5-step binary search, one step per clock.
module normalizer_32
  import normalizer_32_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NORM_W-1:0]  in_data,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NORM_W-1:0]  out_data,
  output logic [NORM_SW-1:0] out_shamt,
  output logic               out_zero
);

  norm_state_t        state, state_nxt;
  logic [2:0]         stage;
  logic [NORM_W-1:0]  work, shifted, work_nxt;
  logic [NORM_SW-1:0] count, amt, count_nxt;
  logic               smode, zero_r, take;

  assign in_ready  = (state == NORM_IDLE);
  assign out_valid = (state == NORM_DONE);
  assign amt       = stage_amt(stage);

  norm_stage u_stage (
    .work        (work),
    .amt         (amt),
    .signed_mode (smode),
    .shifted     (shifted),
    .take        (take)
  );

  // Result of the current search step, whether or not it shifts.
  always_comb begin
    work_nxt  = take ? shifted : work;
    count_nxt = take ? count + amt : count;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORM_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, five search steps in RUN, hold in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      NORM_IDLE: if (in_valid) state_nxt = NORM_RUN;
      NORM_RUN:  if (stage == 3'(NORM_STAGES - 1)) state_nxt = NORM_DONE;
      NORM_DONE: if (out_ready) state_nxt = NORM_IDLE;
      default:   state_nxt = NORM_IDLE;
    endcase
  end

  // Datapath: capture operand, iterate, then load the held result.
  // A zero operand still walks all stages so latency does not depend on data;
  // its accumulated count (31) is discarded in favour of shamt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      work      <= '0;
      count     <= '0;
      smode     <= 1'b0;
      zero_r    <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        NORM_IDLE: begin
          if (in_valid) begin
            work   <= in_data;
            smode  <= in_signed;
            zero_r <= (in_data == '0);
            count  <= '0;
            stage  <= '0;
          end
        end
        NORM_RUN: begin
          work  <= work_nxt;
          count <= count_nxt;
          stage <= stage + 3'd1;
          if (stage == 3'(NORM_STAGES - 1)) begin
            out_data  <= work_nxt;
            out_shamt <= zero_r ? '0 : count_nxt;
            out_zero  <= zero_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer_32.sv
// Directed and random checks of normalizer_32 against a bit-scan reference.
module tb_normalizer_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_shamt;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  normalizer_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: scan from the top for the first bit that breaks the pattern.
  function automatic void model(input logic [31:0] x, input bit s,
                                output logic [31:0] d, output logic [4:0] n,
                                output logic z);
    int k = 0;
    z = (x == 0);
    if (z) begin
      d = 0; n = 0;
    end else begin
      if (!s) while (k < 31 && x[31-k] == 1'b0) k++;
      else    while (k < 31 && x[30-k] == x[31]) k++;
      d = x << k;
      n = 5'(k);
    end
  endfunction

  // Offer an operand in IDLE; returns just after the accept edge.
  task automatic start(input logic [31:0] d, input bit s);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid; must be exactly 5.
  task automatic wait_result();
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    check("latency", 32'(cyc), 32'd5);
  endtask

  task automatic check_result(input string tag, input logic [31:0] x, input bit s);
    logic [31:0] ed, back;
    logic [4:0]  en;
    logic        ez;
    model(x, s, ed, en, ez);
    check({tag, "_data"},  out_data, ed);
    check({tag, "_shamt"}, 32'(out_shamt), 32'(en));
    check({tag, "_zero"},  32'(out_zero), 32'(ez));
    back = s ? 32'($signed(out_data) >>> out_shamt) : (out_data >> out_shamt);
    check({tag, "_restore"}, back, x);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input bit s);
    start(x, s);
    wait_result();
    check_result(tag, x, s);
    handshake();
  endtask

  initial begin
    logic [31:0] hd;
    logic [4:0]  hs;
    logic        hz;
    logic [31:0] x;
    bit          s;

    // Reset state
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_shamt", 32'(out_shamt), 32'd0);
    check("rst_zero",  32'(out_zero), 32'd0);
    #12 rst_n = 1'b1;
    #1 check("rst_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-derived expectations
    run_op("u1", 32'h0000_0001, 1'b0);
    check("u1_lit_data", out_data, 32'h8000_0000);
    check("u1_lit_shamt", 32'(out_shamt), 32'd31);
    run_op("u2", 32'h00F0_0000, 1'b0);
    check("u2_lit_data", out_data, 32'hF000_0000);
    check("u2_lit_shamt", 32'(out_shamt), 32'd8);
    run_op("s3", 32'h0000_0003, 1'b1);
    check("s3_lit_data", out_data, 32'h6000_0000);
    check("s3_lit_shamt", 32'(out_shamt), 32'd29);
    run_op("sF0", 32'hFFFF_FFF0, 1'b1);
    check("sF0_lit_shamt", 32'(out_shamt), 32'd27);
    run_op("sFF", 32'hFFFF_FFFF, 1'b1);
    check("sFF_lit_data", out_data, 32'h8000_0000);
    check("sFF_lit_shamt", 32'(out_shamt), 32'd31);
    check("sFF_lit_zero", 32'(out_zero), 32'd0);
    run_op("uz", 32'h0, 1'b0);
    check("uz_lit_zero", 32'(out_zero), 32'd1);
    run_op("sz", 32'h0, 1'b1);
    check("sz_lit_shamt", 32'(out_shamt), 32'd0);
    run_op("u_top", 32'h8000_0000, 1'b0);
    run_op("s_top", 32'h4000_0000, 1'b1);

    // Backpressure: result held, new offer ignored, then accepted after release
    start(32'h0001_2345, 1'b0);
    wait_result();
    hd = out_data; hs = out_shamt; hz = out_zero;
    in_valid = 1'b1; in_data = 32'hFFFF_8000; in_signed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_data",  out_data, hd);
      check("bp_shamt", 32'(out_shamt), 32'(hs));
      check("bp_zero",  32'(out_zero), 32'(hz));
    end
    check_result("bp_held", 32'h0001_2345, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result();
    check_result("bp_next", 32'hFFFF_8000, 1'b1);
    handshake();

    // Reset during RUN stage 2
    start(32'h0000_0F00, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_data",  out_data, 32'd0);
    check("mid_rst_shamt", 32'(out_shamt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      check("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 32'h0000_0F00, 1'b0);

    // Random operands, spread across shift amounts; both modes
    for (int i = 0; i < 3000; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) x = ~x;
      if ($urandom_range(0, 63) == 0) x = 32'h0;
      run_op("rnd", x, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
